fp_add_arbiter: RTL

Shares one combinational floating_point_adder instance between two requesters. Arbitration is round-robin. Each operation is a valid/ready request followed by a valid/ready response. Operands are registered into the adder, the result and overflow are captured after a configurable settle time, and the block keeps completed-operation and overflow counters for status readout.

---
 rtl/fp_add_arbiter.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/fp_add_arbiter.sv
// Two-requester round-robin front end sharing one combinational IEEE-754 single adder.
// Operands are registered into the adder, the result is captured after EXEC_CYCLES,
// then presented to the owning requester until it is consumed.

// Combinational single-precision adder, round-to-nearest-even, subnormals supported.
module floating_point_adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        enable,
    output logic [31:0] sum,
    output logic        overflowFlag
);

    logic        signA, signB, signL, sameSign, swap;
    logic        nanA, nanB, infA, infB;
    logic [7:0]  expLRaw, expSRaw;
    logic [22:0] fracL, fracS;
    logic [23:0] sigL, sigS;
    logic [9:0]  expL, expS, expDiff, expNorm, normShift, finalExp;
    logic [5:0]  shamt;
    logic [54:0] alignExt;
    logic [26:0] bigExt, smallAl, subRes, mant;
    logic [27:0] addRes;
    logic [4:0]  lz;
    logic        roundUp;
    logic [24:0] rounded;
    logic [23:0] finalSig;

    // Align, add/subtract, normalise, round and pack.
    always_comb begin
        signA    = a[31];
        signB    = b[31];
        nanA     = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        nanB     = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        infA     = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        infB     = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        sameSign = (signA == signB);

        // Larger magnitude goes first so the subtract path never goes negative.
        swap    = b[30:0] > a[30:0];
        signL   = swap ? signB : signA;
        expLRaw = swap ? b[30:23] : a[30:23];
        expSRaw = swap ? a[30:23] : b[30:23];
        fracL   = swap ? b[22:0] : a[22:0];
        fracS   = swap ? a[22:0] : b[22:0];
        sigL    = {expLRaw != 8'd0, fracL};
        sigS    = {expSRaw != 8'd0, fracS};
        expL    = (expLRaw == 8'd0) ? 10'd1 : {2'b00, expLRaw};
        expS    = (expSRaw == 8'd0) ? 10'd1 : {2'b00, expSRaw};

        // Shifts of 28 or more push every bit of the small operand into sticky.
        expDiff  = expL - expS;
        shamt    = (expDiff > 10'd28) ? 6'd28 : expDiff[5:0];
        alignExt = {sigS, 3'b000, 28'd0} >> shamt;
        smallAl  = {alignExt[54:29], alignExt[28] | (|alignExt[27:0])};
        bigExt   = {sigL, 3'b000};

        addRes = {1'b0, bigExt} + {1'b0, smallAl};
        subRes = bigExt - smallAl;

        lz = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (subRes[i]) lz = 5'(26 - i);
        end

        normShift = 10'd0;
        if (sameSign) begin
            if (addRes[27]) begin
                mant    = {addRes[27:2], addRes[1] | addRes[0]};
                expNorm = expL + 10'd1;
            end else begin
                mant    = addRes[26:0];
                expNorm = expL;
            end
        end else begin
            // Stop normalising at the minimum exponent; what remains is subnormal.
            normShift = ({5'd0, lz} > (expL - 10'd1)) ? (expL - 10'd1) : {5'd0, lz};
            mant      = subRes << normShift;
            expNorm   = expL - normShift;
        end

        roundUp = mant[2] & (mant[1] | mant[0] | mant[3]);
        rounded = {1'b0, mant[26:3]} + 25'(roundUp);
        if (rounded[24]) begin
            finalSig = rounded[24:1];
            finalExp = expNorm + 10'd1;
        end else begin
            finalSig = rounded[23:0];
            finalExp = expNorm;
        end

        overflowFlag = 1'b0;
        if (!enable) begin
            sum = 32'd0;
        end else if (nanA || nanB || (infA && infB && !sameSign)) begin
            sum = 32'h7FC0_0000;
        end else if (infA) begin
            sum = {signA, 8'hFF, 23'd0};
        end else if (infB) begin
            sum = {signB, 8'hFF, 23'd0};
        end else if (!sameSign && (subRes == 27'd0)) begin
            sum = 32'd0;
        end else if (finalExp >= 10'd255) begin
            sum          = {signL, 8'hFF, 23'd0};
            overflowFlag = 1'b1;
        end else begin
            sum = {signL, finalSig[23] ? finalExp[7:0] : 8'h00, finalSig[22:0]};
        end
    end

endmodule

module fp_add_arbiter #(
    parameter int unsigned EXEC_CYCLES = 1,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [31:0]      rsp_sum,
    output logic             rsp_ovf,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done,
    output logic [CNT_W-1:0] ovf_count
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} arbState;

    arbState     state, stateNext;
    logic [31:0] opA, opB;
    logic        owner, lastGrant;
    logic [3:0]  execCnt;
    logic        grantValid, grantSel;
    logic        accept, execDone, rspFire;
    logic [31:0] adderSum;
    logic        adderOvf;

    floating_point_adder uAdder (
        .a            (opA),
        .b            (opB),
        .enable       (1'b1),
        .sum          (adderSum),
        .overflowFlag (adderOvf)
    );

    // Round-robin pick: on contention the requester not served last wins.
    always_comb begin
        grantValid = req0_valid | req1_valid;
        grantSel   = (req0_valid && req1_valid) ? ~lastGrant : req1_valid;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= StIdle;
        else     state <= stateNext;
    end

    // Next state and handshake outputs.
    always_comb begin
        stateNext  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        accept     = 1'b0;
        execDone   = 1'b0;
        rspFire    = 1'b0;
        unique case (state)
            StIdle: begin
                if (grantValid) begin
                    req0_ready = ~grantSel;
                    req1_ready = grantSel;
                    accept     = 1'b1;
                    stateNext  = StExec;
                end
            end
            StExec: begin
                if (execCnt == 4'd0) begin
                    execDone  = 1'b1;
                    stateNext = StResp;
                end
            end
            StResp: begin
                rsp0_valid = ~owner;
                rsp1_valid = owner;
                rspFire    = owner ? rsp1_ready : rsp0_ready;
                if (rspFire) stateNext = StIdle;
            end
            default: stateNext = StIdle;
        endcase
        busy = (state != StIdle);
    end

    // Operand capture, settle countdown, result capture and status counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            opA       <= 32'd0;
            opB       <= 32'd0;
            owner     <= 1'b0;
            lastGrant <= 1'b1;
            execCnt   <= 4'd0;
            rsp_sum   <= 32'd0;
            rsp_ovf   <= 1'b0;
            ops_done  <= '0;
            ovf_count <= '0;
        end else begin
            if (accept) begin
                opA       <= grantSel ? req1_a : req0_a;
                opB       <= grantSel ? req1_b : req0_b;
                owner     <= grantSel;
                lastGrant <= grantSel;
                execCnt   <= 4'(EXEC_CYCLES - 1);
            end
            if ((state == StExec) && !execDone) execCnt <= execCnt - 4'd1;
            if (execDone) begin
                rsp_sum <= adderSum;
                rsp_ovf <= adderOvf;
            end
            if (rspFire) begin
                if (ops_done != '1) ops_done <= ops_done + 1'b1;
                if (rsp_ovf && (ovf_count != '1)) ovf_count <= ovf_count + 1'b1;
            end
        end
    end

endmodule
